// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: data widths,
// FSM encoding, the output bundle latched by BufferMEMWB and its reset value.
package mem_access_stage_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] ow;
    logic [BYTE_W-1:0] ob;
    logic [DATA_W-1:0] fwd;
    logic              oc;
    logic              valid;
  } out_bundle_t;

  localparam out_bundle_t OUT_RESET = '0;

  // One EX/MEM request as held across a multi-cycle access.
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] alu;
    logic              byte_op;
    logic              rd;
    logic              wr;
    logic              ctrl;
  } mem_op_t;

endpackage

// File: rtl/mem_access_stage_data_mem.sv
// Byte-wide data memory: two combinational read ports sharing their
// addresses with two independently enabled byte write ports.
module data_mem_bytes
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [BYTE_W-1:0] wd0,
  input  logic [BYTE_W-1:0] wd1,
  output logic [BYTE_W-1:0] rd0,
  output logic [BYTE_W-1:0] rd1
);

  logic [BYTE_W-1:0] mem_array [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we0) mem_array[addr0] <= wd0;
    if (we1) mem_array[addr1] <= wd1;
  end

  assign rd0 = mem_array[addr0];
  assign rd1 = mem_array[addr1];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: big-endian word/byte load/store with LAT-cycle access and upstream stall.
// Optional misaligned-word detection is enabled by defining MEM_ALIGN_CHK_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic              C,
  input  logic              R,
  input  logic              in_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              byte_op,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              ctrl_in,
  output logic [DATA_W-1:0] OW,
  output logic [BYTE_W-1:0] OB,
  output logic [DATA_W-1:0] OF,
  output logic              OC,
  output logic              out_valid,
  output logic              stall
`ifdef MEM_ALIGN_CHK_EN
  ,
  output logic              misalign
`endif
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_op_t     cap_q, cap_d;
  out_bundle_t out_q, out_d;
`ifdef MEM_ALIGN_CHK_EN
  logic        mis_q, mis_d;
`endif

  mem_op_t           live_op, op;
  logic              acc_go;
  logic [ADDR_W-1:0] a, pa0, pa1;
  logic              misal, is_st, we0, we1;
  logic [BYTE_W-1:0] wd0, wd1, rd0, rd1, rb;
  logic              unused_op_bits;

  assign live_op = '{addr: addr, wdata: wdata, alu: alu_res, byte_op: byte_op,
                     rd: mem_rd, wr: mem_wr, ctrl: ctrl_in};
  // With LAT=1 the access uses the live request; otherwise the captured one.
  assign op    = (state_q == ST_BUSY) ? cap_q : live_op;
  assign a     = op.addr[ADDR_W-1:0];
  assign pa0   = {a[ADDR_W-1:1], 1'b0};
  assign pa1   = {a[ADDR_W-1:1], 1'b1};
  assign misal = ALIGN_CHK & ~op.byte_op & a[0];
  assign is_st = op.wr;
  assign rb    = a[0] ? rd1 : rd0;
  assign unused_op_bits = ^{op.addr[DATA_W-1:ADDR_W], op.rd};

  // Reset on the completing edge aborts the write.
  assign we0 = acc_go & ~R & is_st & ~misal & (~op.byte_op | ~a[0]);
  assign we1 = acc_go & ~R & is_st & ~misal & (~op.byte_op |  a[0]);
  assign wd0 = op.byte_op ? op.wdata[BYTE_W-1:0] : op.wdata[DATA_W-1:BYTE_W];
  assign wd1 = op.wdata[BYTE_W-1:0];

  data_mem_bytes #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (C),
    .addr0 (pa0),
    .addr1 (pa1),
    .we0   (we0),
    .we1   (we1),
    .wd0   (wd0),
    .wd1   (wd1),
    .rd0   (rd0),
    .rd1   (rd1)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    out_d     = out_q;
    out_d.valid = 1'b0;
    acc_go    = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    mis_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!mem_rd && !mem_wr) begin
            out_d = '{ow: '0, ob: '0, fwd: alu_res, oc: ctrl_in, valid: 1'b1};
          end else if (LAT == 1) begin
            acc_go = 1'b1;
          end else begin
            cap_d   = live_op;
            cnt_d   = CNT_LOAD;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          acc_go  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (acc_go) begin
      if (is_st || misal) begin
        out_d.ow = '0;
        out_d.ob = '0;
      end else if (op.byte_op) begin
        out_d.ob = rb;
        out_d.ow = {{(DATA_W-BYTE_W){1'b0}}, rb};
      end else begin
        out_d.ow = {rd0, rd1};
        out_d.ob = rd1;
      end
      out_d.fwd   = op.alu;
      out_d.oc    = op.ctrl;
      out_d.valid = 1'b1;
`ifdef MEM_ALIGN_CHK_EN
      mis_d = misal;
`endif
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      out_q   <= OUT_RESET;
`ifdef MEM_ALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
`ifdef MEM_ALIGN_CHK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign OW        = out_q.ow;
  assign OB        = out_q.ob;
  assign OF        = out_q.fwd;
  assign OC        = out_q.oc;
  assign out_valid = out_q.valid;
  assign stall     = (state_q == ST_BUSY);
`ifdef MEM_ALIGN_CHK_EN
  assign misalign  = mis_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level memory model,
// per-cycle compare against it, plus directed literal expectations.
module tb_mem_access_stage;

  localparam int ADDR_W = 8;
  localparam int LAT    = 2;
  localparam int MEM_N  = 1 << ADDR_W;
`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        C = 1'b0;
  logic        R = 1'b1;
  logic        in_valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, byte_op = 1'b0, ctrl_in = 1'b0;
  logic [15:0] addr = '0, wdata = '0, alu_res = '0;
  logic [15:0] OW, OF;
  logic [7:0]  OB;
  logic        OC, out_valid, stall;
`ifdef MEM_ALIGN_CHK_EN
  logic        misalign;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  mem_access_stage #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .C(C), .R(R), .in_valid(in_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .byte_op(byte_op), .addr(addr), .wdata(wdata), .alu_res(alu_res),
    .ctrl_in(ctrl_in), .OW(OW), .OB(OB), .OF(OF), .OC(OC),
    .out_valid(out_valid), .stall(stall)
`ifdef MEM_ALIGN_CHK_EN
    , .misalign(misalign)
`endif
  );

  always #5 C = ~C;

  // ---------------- behavioural model ----------------
  logic [7:0]  mem_m [MEM_N];
  logic [15:0] e_ow = '0, e_of = '0;
  logic [7:0]  e_ob = '0;
  logic        e_oc = 1'b0, e_valid = 1'b0, e_stall = 1'b0, e_mis = 1'b0;
  bit          pend = 1'b0;
  int          pend_done = 0;
  int          edge_n = 0;
  logic        p_wr, p_byte, p_ctrl;
  logic [15:0] p_addr, p_wdata, p_alu;

  task automatic complete(input logic wr, input logic byt, input logic [15:0] ad,
                          input logic [15:0] wd, input logic [15:0] alu, input logic ct);
    int a, base;
    bit mis;
    a    = int'(ad) % MEM_N;
    base = a - (a % 2);
    mis  = ALIGN_CHK && !byt && (a % 2 == 1);
    if (wr) begin
      if (!mis) begin
        if (byt) mem_m[a] = wd[7:0];
        else begin
          mem_m[base]   = wd[15:8];
          mem_m[base+1] = wd[7:0];
        end
      end
      e_ow = '0;
      e_ob = '0;
    end else if (mis) begin
      e_ow = '0;
      e_ob = '0;
    end else if (byt) begin
      e_ob = mem_m[a];
      e_ow = {8'h00, mem_m[a]};
    end else begin
      e_ow = {mem_m[base], mem_m[base+1]};
      e_ob = mem_m[base+1];
    end
    e_of    = alu;
    e_oc    = ct;
    e_valid = 1'b1;
    e_mis   = mis;
  endtask

  always @(posedge C) begin
    if (R) begin
      e_ow = '0; e_ob = '0; e_of = '0; e_oc = 1'b0;
      e_valid = 1'b0; e_mis = 1'b0; pend = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_mis   = 1'b0;
      if (pend) begin
        if (edge_n == pend_done) begin
          complete(p_wr, p_byte, p_addr, p_wdata, p_alu, p_ctrl);
          pend = 1'b0;
        end
      end else if (in_valid) begin
        if (!mem_rd && !mem_wr) begin
          e_ow = '0; e_ob = '0; e_of = alu_res; e_oc = ctrl_in; e_valid = 1'b1;
        end else if (LAT == 1) begin
          complete(mem_wr, byte_op, addr, wdata, alu_res, ctrl_in);
        end else begin
          pend = 1'b1;
          pend_done = edge_n + LAT - 1;
          p_wr = mem_wr; p_byte = byte_op; p_addr = addr;
          p_wdata = wdata; p_alu = alu_res; p_ctrl = ctrl_in;
        end
      end
    end
    e_stall = pend;
    edge_n++;
  end

  // ---------------- comparison ----------------
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge C) begin
    if (chk_en) begin
      chk("stall",     16'(stall),     16'(e_stall));
      chk("out_valid", 16'(out_valid), 16'(e_valid));
      chk("OW",        OW,             e_ow);
      chk("OB",        16'(OB),        16'(e_ob));
      chk("OF",        OF,             e_of);
      chk("OC",        16'(OC),        16'(e_oc));
`ifdef MEM_ALIGN_CHK_EN
      chk("misalign",  16'(misalign),  16'(e_mis));
`endif
    end
  end

  // Issue one request from an idle DUT and wait (bounded) for its out_valid pulse.
  task automatic do_op(input logic rd, input logic wr, input logic byt,
                       input logic [15:0] ad, input logic [15:0] wd,
                       input logic [15:0] alu, input logic ct, input bit show,
                       output int stalls);
    mem_rd = rd; mem_wr = wr; byte_op = byt; addr = ad; wdata = wd;
    alu_res = alu; ctrl_in = ct; in_valid = 1'b1;
    @(posedge C); @(negedge C);
    in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    stalls = 0;
    for (int k = 0; k < LAT + 4 && !out_valid; k++) begin
      if (stall) stalls++;
      @(posedge C); @(negedge C);
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL op_timeout got=out_valid_low exp=pulse addr=%h t=%0t", ad, $time);
    end
    if (show)
      $display("txn rd=%0d wr=%0d byte=%0d addr=%h wdata=%h -> OW=%h OB=%h OF=%h OC=%0d stalls=%0d",
               rd, wr, byt, ad, wd, OW, OB, OF, OC, stalls);
  endtask

  initial begin
    int s;
    R = 1'b1;
    repeat (3) @(posedge C);
    @(negedge C);
    chk_en = 1'b1;
    chk("rst OW", OW, 16'h0000);
    chk("rst OF", OF, 16'h0000);
    chk("rst valid_stall", {14'b0, out_valid, stall}, 16'h0000);
    R = 1'b0;

    // Fill memory with a known pattern: word(A) = {A, A^5A}.
    for (int w = 0; w < MEM_N; w += 2)
      do_op(1'b0, 1'b1, 1'b0, 16'(w), {8'(w), 8'(w) ^ 8'h5A}, 16'h0000, 1'b0, 1'b0, s);

    do_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'hA237, 16'h1111, 1'b1, 1'b1, s);
    chk("st stalls", 16'(s), 16'(LAT - 1));
    do_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h2222, 1'b0, 1'b1, s);
    chk("ldw OW", OW, 16'hA237);
    chk("ldw OB", 16'(OB), 16'h0037);
    chk("ldw OF", OF, 16'h2222);
    chk("ldw stalls", 16'(s), 16'(LAT - 1));

    do_op(1'b0, 1'b1, 1'b1, 16'h0011, 16'h55F0, 16'h0000, 1'b0, 1'b1, s);
    do_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, s);
    chk("ldw2 OW", OW, 16'hA2F0);
    chk("ldw2 OB", 16'(OB), 16'h00F0);
    do_op(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, s);
    chk("ldb OW", OW, 16'h00A2);
    chk("ldb OB", 16'(OB), 16'h00A2);

    do_op(1'b0, 1'b0, 1'b0, 16'h0033, 16'hBEEF, 16'hF500, 1'b1, 1'b1, s);
    chk("pass OF", OF, 16'hF500);
    chk("pass OC_OW", {OC, OW[14:0]}, 16'h8000);
    chk("pass stalls", 16'(s), 16'h0000);

    // Reset while the store is in flight.
    mem_wr = 1'b1; mem_rd = 1'b0; byte_op = 1'b0; addr = 16'h0020;
    wdata = 16'h8400; alu_res = 16'h7777; in_valid = 1'b1;
    @(posedge C); @(negedge C);
    chk("abort busy", 16'(stall), 16'h0001);
    in_valid = 1'b0; mem_wr = 1'b0; R = 1'b1;
    @(posedge C); @(negedge C);
    chk("abort OF", OF, 16'h0000);
    chk("abort flags", {14'b0, out_valid, stall}, 16'h0000);
    $display("txn reset during store addr=0020 wdata=8400 -> OW=%h OF=%h stall=%0d", OW, OF, stall);
    R = 1'b0;
    do_op(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b1, s);
    chk("abort ld", OW, 16'h207A);

    do_op(1'b0, 1'b1, 1'b0, 16'h01FE, 16'h1234, 16'h0000, 1'b0, 1'b1, s);
    do_op(1'b1, 1'b0, 1'b0, 16'h00FE, 16'h0000, 16'h0000, 1'b0, 1'b1, s);
    chk("wrap ld", OW, 16'h1234);

`ifdef MEM_ALIGN_CHK_EN
    do_op(1'b0, 1'b1, 1'b0, 16'h0011, 16'hDEAD, 16'h0000, 1'b0, 1'b1, s);
    chk("mis st flag", 16'(misalign), 16'h0001);
    do_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, s);
    chk("mis ld unchanged", OW, 16'hA2F0);
    chk("mis ld flag", 16'(misalign), 16'h0000);
`endif

    // Free-running random traffic, ignoring stall, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      R        = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      mem_rd   = 1'($urandom);
      mem_wr   = 1'($urandom);
      byte_op  = 1'($urandom);
      ctrl_in  = 1'($urandom);
      addr     = 16'($urandom);
      wdata    = 16'($urandom);
      alu_res  = 16'($urandom);
      @(posedge C); @(negedge C);
    end
    R = 1'b0; in_valid = 1'b0;
    repeat (LAT + 2) @(negedge C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 16-bit pipeline: sits between the EX/MEM buffer and BufferMEMWB.
- Performs data-memory load/store (word or byte) against an internal byte-addressed data memory with configurable access latency.
- Forwards ALU result and control bits.
- Produces exactly the word/byte/forward/ctrl bundle that BufferMEMWB latches; stalls upstream during multi-cycle accesses.

Parameters:
ADDR_W, 8, data-memory address width in bytes (memory = 2^ADDR_W bytes)
LAT, 2, memory access latency in cycles (legal >= 1)

Ports:
C  input  1  clock, all state updates on rising edge
R  input  1  synchronous active-high reset
in_valid  input  1  EX/MEM bundle valid this cycle
mem_rd  input  1  load request
mem_wr  input  1  store request
byte_op  input  1  1 = byte access, 0 = word access
addr  input  16  byte address (low ADDR_W bits used)
wdata  input  16  store data
alu_res  input  16  ALU result, forwarded unchanged
ctrl_in  input  1  WB control bit, forwarded unchanged
OW  output  16  load word result (to BufferMEMWB IW)
OB  output  8  load byte result (to BufferMEMWB IB)
OF  output  16  forwarded ALU result (to BufferMEMWB IF)
OC  output  1  forwarded control (to BufferMEMWB IC)
out_valid  output  1  output bundle valid, one-cycle pulse per accepted bundle
stall  output  1  upstream must hold inputs while high
`ifdef MEM_ALIGN_CHK_EN
misalign  output  1  misaligned word access flag, aligned with out_valid
`endif

Behaviour:
- One clock C; reset R is synchronous and active-high.
- Reset: OW=0, OB=0, OF=0, OC=0, out_valid=0, stall=0, FSM=IDLE, latency counter=0. Memory contents are not cleared.
- FSM states:
  - IDLE: accepts inputs when in_valid=1.
    - If neither mem_rd nor mem_wr: pass-through. Next edge OF=alu_res, OC=ctrl_in, OW=0, OB=0, out_valid=1. Stays IDLE.
    - If memory op and LAT=1: access completes at the accepting edge. Outputs as below, out_valid=1, stays IDLE.
    - If memory op and LAT>1: capture addr/wdata/byte_op/rd/wr/alu_res/ctrl_in, load counter=LAT-1, go to BUSY.
  - BUSY: stall=1 (decoded from state), inputs ignored. Counter decrements each edge. At the edge where the counter reaches 0, perform the access, drive outputs, set out_valid=1, return to IDLE.
- Latency: a memory op accepted at edge t produces out_valid=1 in the cycle following edge t+LAT-1. Stall is high for LAT-1 cycles.
- Memory layout is big-endian. A word at even address A has high byte mem[A] and low byte mem[A+1]. Word accesses use addr with bit0 forced to 0.
- Load word: OW = word, OB = low byte.
- Load byte: OB = mem[addr], OW = {8'h00, OB}.
- Store word: writes both bytes. Store byte: writes mem[addr] = wdata[7:0]. Stores drive OW=0, OB=0.
- OF and OC are always the captured alu_res and ctrl_in.
- mem_rd and mem_wr both high: treated as store, OW=OB=0.
- Addresses wrap modulo 2^ADDR_W; upper address bits are ignored.
- in_valid=0 in IDLE: out_valid=0 next cycle; OW/OB/OF/OC hold their previous values.
- Reset mid-BUSY: operation aborted, no memory write occurs, return to IDLE with reset output values.
- Write-then-read ordering: a load accepted after a store completes sees the stored data.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - Word access with addr[0]=1 sets misalign=1 alongside out_valid.
  - A misaligned store performs no write; a misaligned load returns OW=0, OB=0.
  - misalign resets to 0.
- Undefined: port absent; addr[0] is silently ignored for word accesses.

Decomposition:
- Shared package holds:
  - data width constant 16, byte width 8
  - FSM state encoding IDLE/BUSY
  - reset values for the output bundle
- One natural sub-module, data_mem_bytes: 2^ADDR_W x 8 synchronous-write array with two byte read ports and byte write enables. The FSM and output registers stay in mem_access_stage.

Test Plan:
- Store word 16'hA237 at 0x10, then load word at 0x10 (LAT=2) -> stall high 1 cycle per op; OW=A237, OB=37, out_valid pulse.
- Store byte 8'hF0 at 0x11, then load word at 0x10 -> OW=A2F0, OB=F0; load byte at 0x10 -> OW=00A2, OB=A2.
- Pass-through with alu_res=16'hF500, ctrl_in=1, no mem op -> next cycle OF=F500, OC=1, OW=0, OB=0, stall never asserted.
- Store word 16'h8400 at 0x20, assert R during BUSY -> outputs 0, IDLE; subsequent load at 0x20 returns the prior contents, not 8400.
- Address wrap: store word 16'h1234 at 16'h01FE with ADDR_W=8 -> load word at 0x00FE returns 1234.
- With MEM_ALIGN_CHK_EN: store word at 0x11 -> misalign=1, no write; load at 0x10 unchanged.
